// File: rtl/regbus_master.sv
// regbus_master: turns host read/write burst commands into one-access-per-cycle register bus traffic.
// Define REGBUS_MASTER_RANGE_CHECK_EN to reject bursts that run past TOTAL_REGS.
module regbus_master #(
  parameter int DATA_WIDTH = 16,
  parameter int TOTAL_REGS = 63,
  parameter int ADDR_WIDTH = $clog2(TOTAL_REGS),
  parameter int LEN_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_write_en,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic accept;
  logic reject;
  logic wr_beat;
  logic rd_cap;
  logic rd_pop;
  logic last;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign wr_ready  = (state_q == WRITE) && !rst;
  assign busy      = (state_q != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_beat   = wr_valid && wr_ready;
  assign rd_pop    = rd_valid && rd_ready;
  assign rd_cap    = (state_q == READ) && (!rd_valid || rd_ready);
  assign last      = (cnt_q == '0);

`ifdef REGBUS_MASTER_RANGE_CHECK_EN
  localparam int SUM_W = ADDR_WIDTH + LEN_WIDTH + 1;

  logic [SUM_W-1:0] end_addr;

  assign end_addr = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
  assign reject   = (end_addr >= SUM_W'(TOTAL_REGS));
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (reject) begin
            state_d = DONE;
          end else if (cmd_write) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE: begin
        if (wr_beat && last) state_d = DONE;
      end
      READ: begin
        if (rd_cap && last) state_d = DONE;
      end
      DONE: begin
        if (!rd_valid || rd_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // bus_addr always holds the address whose rdata the next capture takes
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      cnt_q        <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_last      <= 1'b0;
      err          <= 1'b0;
      bus_addr     <= '0;
      bus_write_en <= 1'b0;
      bus_wdata    <= '0;
    end else begin
      bus_write_en <= 1'b0;
      err          <= 1'b0;
      if (rd_pop) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
      if (accept) begin
        ptr_q <= cmd_addr;
        cnt_q <= cmd_len;
        err   <= reject;
        if (!reject && !cmd_write) bus_addr <= cmd_addr;
      end
      if (wr_beat) begin
        bus_write_en <= 1'b1;
        bus_addr     <= ptr_q;
        bus_wdata    <= wr_data;
        ptr_q        <= ptr_q + 1'b1;
        cnt_q        <= cnt_q - 1'b1;
      end
      if (rd_cap) begin
        rd_data  <= bus_rdata;
        rd_valid <= 1'b1;
        rd_last  <= last;
        cnt_q    <= cnt_q - 1'b1;
        if (!last) begin
          ptr_q    <= ptr_q + 1'b1;
          bus_addr <= ptr_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regbus_master.sv
// tb_regbus_master: directed and random bursts against a queue-based bus/stream model.
// Honours REGBUS_MASTER_RANGE_CHECK_EN in the reference model.
module tb_regbus_master;

  localparam int DW = 16;
  localparam int AW = 6;
  localparam int LW = 6;
`ifdef REGBUS_MASTER_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          err;
  logic [AW-1:0] bus_addr;
  logic          bus_write_en;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;

  logic [DW-1:0]    regs   [64];
  logic [DW-1:0]    shadow [64];
  logic [AW+DW-1:0] exp_wr [$];
  logic [DW:0]      exp_rd [$];
  logic [DW-1:0]    wq [$];
  logic [DW-1:0]    dq [$];
  int               gq [$];
  int               wcyc [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int rd_beats = 0;
  int rd_mode = 0;

  regbus_master dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .busy         (busy),
    .err          (err),
    .bus_addr     (bus_addr),
    .bus_write_en (bus_write_en),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  // register map model: async read, write on the edge
  assign bus_rdata = regs[bus_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) regs[i] <= 16'hA000 + 16'(i);
    end else if (bus_write_en) begin
      regs[bus_addr] <= bus_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (bus_write_en === 1'b1) begin
      wcyc.push_back(cyc);
      if (exp_wr.size() == 0) check("bus_wr_extra", 32'(bus_write_en), 0);
      else check("bus_wr", 32'({bus_addr, bus_wdata}), 32'(exp_wr.pop_front()));
    end
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      rd_beats++;
      if (exp_rd.size() == 0) check("rd_extra", 32'(rd_valid), 0);
      else check("rd_beat", 32'({rd_last, rd_data}), 32'(exp_rd.pop_front()));
    end
  end

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rd_mode == 0) rd_ready = 1'b1;
      else if (rd_mode == 1) rd_ready = ~rd_ready;
      else rd_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic bit rejects(input int a, input int len);
    return RANGE_CHK && ((a + len) >= 63);
  endfunction

  task automatic expect_cmd(input bit w, input int a, input int len,
                            input int gap_pct);
    int ad;
    logic [DW-1:0] d;
    wq.delete();
    gq.delete();
    if (rejects(a, len)) begin
      exp_err++;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      ad = (a + i) % 64;
      if (w) begin
        d = (dq.size() != 0) ? dq.pop_front() : 16'($urandom);
        shadow[ad] = d;
        wq.push_back(d);
        gq.push_back(($urandom_range(0, 99) < gap_pct) ?
                     int'($urandom_range(1, 2)) : 0);
        exp_wr.push_back({6'(ad), d});
      end else begin
        exp_rd.push_back({i == len, shadow[ad]});
      end
    end
  endtask

  task automatic do_cmd(input bit w, input int a, input int len);
    bit ok;
    ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(len);
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", 32'(ok), 1);
  endtask

  task automatic feed();
    bit ok;
    int gap;
    while (wq.size() != 0) begin
      wr_valid = 1'b0;
      gap = (gq.size() != 0) ? gq.pop_front() : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      wr_valid = 1'b1;
      wr_data  = wq.pop_front();
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
        @(negedge clk);
        ok = wr_ready;
        @(posedge clk);
        #1;
      end
      check("wr_accept", 32'(ok), 1);
      if (!ok) wq.delete();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      done = !busy && exp_wr.size() == 0 && exp_rd.size() == 0;
    end
    check("idle", 32'(done), 1);
    if (!done) begin
      exp_wr.delete();
      exp_rd.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check(tag, 32'({rd_valid, rd_last, err, busy, bus_write_en}), 0);
    check({tag, "_data"}, 32'({rd_data, bus_wdata}), 0);
    check({tag, "_addr"}, 32'(bus_addr), 0);
  endtask

  initial begin
    int base;
    bit ok;
    bit w;
    int a;
    int len;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    for (int i = 0; i < 64; i++) shadow[i] = 16'hA000 + 16'(i);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 1);
    check_zero("post_rst");
    @(posedge clk);
    #1;

    dq = '{16'h1234};
    expect_cmd(1'b1, 0, 0, 0);
    do_cmd(1'b1, 0, 0);
    feed();
    @(negedge clk);
    check("sw_we", 32'({bus_write_en, busy}), 32'h3);
    @(negedge clk);
    check("sw_busy_drop", 32'({bus_write_en, busy}), 0);
    wait_idle();

    dq = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    expect_cmd(1'b1, 1, 3, 0);
    gq[2] = 1;
    wcyc.delete();
    do_cmd(1'b1, 1, 3);
    feed();
    wait_idle();
    check("bw_count", 32'(wcyc.size()), 4);
    if (wcyc.size() == 4) begin
      check("bw_gap01", 32'(wcyc[1] - wcyc[0]), 1);
      check("bw_gap12", 32'(wcyc[2] - wcyc[1]), 2);
      check("bw_gap23", 32'(wcyc[3] - wcyc[2]), 1);
    end

    rd_mode = 1;
    base = rd_beats;
    expect_cmd(1'b0, 31, 7, 0);
    do_cmd(1'b0, 31, 7);
    wait_idle();
    check("rd31_beats", 32'(rd_beats - base), 8);

    rd_mode = 0;
    base = err_cnt;
    expect_cmd(1'b0, 60, 5, 0);
    do_cmd(1'b0, 60, 5);
    wait_idle();
    check("range_err", 32'(err_cnt - base), RANGE_CHK ? 1 : 0);

    rd_mode = 2;
    base = rd_beats;
    expect_cmd(1'b0, 5, 3, 0);
    do_cmd(1'b0, 5, 3);
    expect_cmd(1'b0, 40, 2, 0);
    cmd_valid = 1'b1;
    cmd_addr = AW'(40);
    cmd_len = LW'(2);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready;
      if (ok) begin
        check("held_busy", 32'(busy), 0);
        check("held_drained", 32'(rd_beats - base), 4);
      end
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    check("held_accept", 32'(ok), 1);
    wait_idle();

    rd_mode = 0;
    expect_cmd(1'b1, 10, 1, 0);
    do_cmd(1'b1, 10, 7);
    feed();
    wr_valid = 1'b1;
    wr_data = 16'hDEAD;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 1);
    check_zero("mid_rst");
    @(posedge clk);
    #1;
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a = int'($urandom_range(0, 63));
      len = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 12));
      rd_mode = int'($urandom_range(0, 2));
      expect_cmd(w, a, len, 30);
      do_cmd(w, a, len);
      if (w) feed();
      wait_idle();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    check("err_total", 32'(err_cnt), 32'(exp_err));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
